bnn_xnor_accum: RTL and testbench

Binary-neuron accumulator placed directly downstream of the 7-bit layer address counter in the Binary-MLP datapath. While the counter steps through weight/activation addresses, this block consumes one packed weight word and one packed activation word per enabled cycle. It accumulates the XNOR-popcount of each pair and, on the last word, produces the neuron's pre-activation sum and its binarised output by threshold compare. It drives `busy`/`done` back to the layer controller.

---
 rtl/bnn_xnor_accum_if.sv | 29 ++
 rtl/bnn_xnor_accum.sv | 128 ++++++++++++
 tb/tb_bnn_xnor_accum.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/bnn_xnor_accum_if.sv
// Bus between the layer controller/address counter and the binary-neuron
// accumulator: neuron start, word-pair stream and the result/handshake.
interface bnn_xnor_accum_if #(
    parameter int WORD_W = 16,
    parameter int ACC_W  = 12
);
    logic              start;
    logic [ACC_W-1:0]  threshold;
    logic              valid_in;
    logic              last_in;
    logic [WORD_W-1:0] w_word;
    logic [WORD_W-1:0] x_word;
    logic              busy;
    logic              done;
    logic [ACC_W-1:0]  acc_out;
    logic              y_bit;

    // Controller / counter side
    modport master (
        output start, threshold, valid_in, last_in, w_word, x_word,
        input  busy, done, acc_out, y_bit
    );

    // Accumulator side
    modport slave (
        input  start, threshold, valid_in, last_in, w_word, x_word,
        output busy, done, acc_out, y_bit
    );
endinterface

// File: rtl/bnn_xnor_accum.sv
// Binary-neuron accumulator: sums XNOR-popcount of weight/activation word
// pairs, saturating, and on the last pair produces the pre-activation sum and
// its binarised value (sum >= latched threshold). Three-state FSM IDLE/ACC/DONE.
module bnn_xnor_accum #(
    parameter int WORD_W = 16,
    parameter int ACC_W  = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    bnn_xnor_accum_if.slave      bus
);

    // Width of a single popcount term (0..WORD_W)
    localparam int CNT_W = $clog2(WORD_W + 1);
    // Sum width wide enough that acc + term can never wrap before saturating
    localparam int SUM_W = ((ACC_W > CNT_W) ? ACC_W : CNT_W) + 1;
    localparam logic [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  thr_q, thr_d;
    logic [ACC_W-1:0]  acc_out_q, acc_out_d;
    logic              y_q, y_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [CNT_W-1:0]  term_s;
    logic [SUM_W-1:0]  sum_s;
    logic [ACC_W-1:0]  sat_s;

    // Count of set bits in a packed word
    function automatic logic [CNT_W-1:0] popcount(input logic [WORD_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < WORD_W; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Per-cycle XNOR-popcount term and saturating running sum
    always_comb begin
        term_s = popcount(~(bus.w_word ^ bus.x_word));
        sum_s  = {{(SUM_W-ACC_W){1'b0}}, acc_q} + {{(SUM_W-CNT_W){1'b0}}, term_s};
        if (sum_s > ACC_MAX) begin
            sat_s = ACC_MAX[ACC_W-1:0];
        end else begin
            sat_s = sum_s[ACC_W-1:0];
        end
    end

    // Next-state, accumulator and result logic
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        thr_d     = thr_q;
        acc_out_d = acc_out_q;
        y_d       = y_q;
        case (state_q)
            ST_IDLE: begin
                // valid_in/last_in are deliberately ignored here, even with start
                if (bus.start) begin
                    acc_d   = {ACC_W{1'b0}};
                    thr_d   = bus.threshold;
                    state_d = ST_ACC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (bus.valid_in) begin
                    acc_d = sat_s;
                    if (bus.last_in) begin
                        acc_out_d = sat_s;
                        y_d       = (sat_s >= thr_q);
                        state_d   = ST_DONE;
                    end else begin
                        state_d = ST_ACC;
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_DONE: begin
                // Leave unconditionally so a held end flag is never re-added
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= {ACC_W{1'b0}};
            thr_q     <= {ACC_W{1'b0}};
            acc_out_q <= {ACC_W{1'b0}};
            y_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            thr_q     <= thr_d;
            acc_out_q <= acc_out_d;
            y_q       <= y_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.acc_out = acc_out_q;
    assign bus.y_bit   = y_q;

endmodule

// File: tb/tb_bnn_xnor_accum.sv
// Directed bench for bnn_xnor_accum: a default instance (ACC_W=12) and a
// narrow instance (ACC_W=5) driven with the same stimulus for saturation.
module tb_bnn_xnor_accum;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   done_cnt;

    bnn_xnor_accum_if #(.WORD_W(16), .ACC_W(12)) bus_a ();
    bnn_xnor_accum_if #(.WORD_W(16), .ACC_W(5))  bus_b ();

    bnn_xnor_accum #(.WORD_W(16), .ACC_W(12)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    bnn_xnor_accum #(.WORD_W(16), .ACC_W(5))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic st, input logic [11:0] thr, input logic v,
                          input logic l, input logic [15:0] w, input logic [15:0] x);
        bus_a.start = st; bus_a.threshold = thr;      bus_a.valid_in = v;
        bus_a.last_in = l; bus_a.w_word = w;          bus_a.x_word = x;
        bus_b.start = st; bus_b.threshold = thr[4:0]; bus_b.valid_in = v;
        bus_b.last_in = l; bus_b.w_word = w;          bus_b.x_word = x;
    endtask

    // One clock edge, then settle 1 time unit; counts done pulses seen
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus_a.done === 1'b1) done_cnt++;
    endtask

    task automatic start_neuron(input logic [11:0] thr);
        set_in(1'b1, thr, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        set_in(1'b0, 12'd0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic pair(input logic [15:0] w, input logic [15:0] x, input logic l);
        set_in(1'b0, 12'd0, 1'b1, l, w, x);
        tick();
        set_in(1'b0, 12'd0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_in(1'b0, 12'd0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick(); tick();
        checks++; if (bus_a.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus_a.busy); end
        checks++; if (bus_a.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", bus_a.done); end
        checks++; if (bus_a.acc_out !== 12'd0) begin failures++; $display("FAIL reset_acc: got %0d want 0", bus_a.acc_out); end
        checks++; if (bus_a.y_bit !== 1'b0) begin failures++; $display("FAIL reset_y: got %b want 0", bus_a.y_bit); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_full_match();
        done_cnt = 0;
        start_neuron(12'd32);
        checks++; if (bus_a.busy !== 1'b1) begin failures++; $display("FAIL full_busy_start: got %b want 1", bus_a.busy); end
        for (int i = 0; i < 3; i++) pair(16'hFFFF, 16'hFFFF, 1'b0);
        checks++; if (bus_a.done !== 1'b0) begin failures++; $display("FAIL full_early_done: got %b want 0", bus_a.done); end
        pair(16'hFFFF, 16'hFFFF, 1'b1);
        checks++; if (bus_a.acc_out !== 12'd64) begin failures++; $display("FAIL full_acc: got %0d want 64", bus_a.acc_out); end
        checks++; if (bus_a.y_bit !== 1'b1) begin failures++; $display("FAIL full_y: got %b want 1", bus_a.y_bit); end
        checks++; if (bus_a.done !== 1'b1 || bus_a.busy !== 1'b1) begin failures++; $display("FAIL full_done_pulse: got done=%b busy=%b want 1 1", bus_a.done, bus_a.busy); end
        tick();
        checks++; if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b0) begin failures++; $display("FAIL full_after: got done=%b busy=%b want 0 0", bus_a.done, bus_a.busy); end
    endtask

    task automatic test_zero_match();
        for (int r = 0; r < 2; r++) begin
            done_cnt = 0;
            start_neuron((r == 0) ? 12'd1 : 12'd0);
            pair(16'h0000, 16'hFFFF, 1'b0);
            pair(16'h0000, 16'hFFFF, 1'b0);
            pair(16'h0000, 16'hFFFF, 1'b1);
            checks++; if (bus_a.acc_out !== 12'd0) begin failures++; $display("FAIL zero_acc_%0d: got %0d want 0", r, bus_a.acc_out); end
            checks++; if (bus_a.y_bit !== ((r == 0) ? 1'b0 : 1'b1)) begin failures++; $display("FAIL zero_y_%0d: got %b want %b", r, bus_a.y_bit, (r != 0)); end
            tick();
            checks++; if (done_cnt !== 1) begin failures++; $display("FAIL zero_done_cnt_%0d: got %0d want 1", r, done_cnt); end
        end
    endtask

    task automatic test_gaps();
        for (int r = 0; r < 2; r++) begin
            done_cnt = 0;
            start_neuron((r == 0) ? 12'd24 : 12'd25);
            pair(16'h00FF, 16'h0000, 1'b0);
            tick(); tick();
            pair(16'hAAAA, 16'h5555, 1'b0);
            tick(); tick();
            pair(16'h1234, 16'h1234, 1'b1);
            checks++; if (bus_a.acc_out !== 12'd24) begin failures++; $display("FAIL gaps_acc_%0d: got %0d want 24", r, bus_a.acc_out); end
            checks++; if (bus_a.y_bit !== ((r == 0) ? 1'b1 : 1'b0)) begin failures++; $display("FAIL gaps_y_%0d: got %b want %b", r, bus_a.y_bit, (r == 0)); end
            tick();
            checks++; if (done_cnt !== 1) begin failures++; $display("FAIL gaps_done_cnt_%0d: got %0d want 1", r, done_cnt); end
        end
    endtask

    task automatic test_ignored();
        done_cnt = 0;
        // valid/last in IDLE without start
        set_in(1'b0, 12'd0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        tick(); tick();
        checks++; if (bus_a.busy !== 1'b0 || done_cnt !== 0) begin failures++; $display("FAIL ign_idle: got busy=%b dones=%0d want 0 0", bus_a.busy, done_cnt); end
        // valid/last in the start cycle
        set_in(1'b1, 12'd41, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        tick();
        checks++; if (bus_a.busy !== 1'b1) begin failures++; $display("FAIL ign_start_busy: got %b want 1", bus_a.busy); end
        // start pulsed mid-ACC with a different threshold: 16
        set_in(1'b1, 12'd0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
        tick();
        pair(16'h00FF, 16'h0000, 1'b0);   // 8
        pair(16'hFFFF, 16'hFFFF, 1'b1);   // 16 -> 40
        checks++; if (bus_a.acc_out !== 12'd40) begin failures++; $display("FAIL ign_acc: got %0d want 40", bus_a.acc_out); end
        checks++; if (bus_a.y_bit !== 1'b0) begin failures++; $display("FAIL ign_y: got %b want 0", bus_a.y_bit); end
        // end flag held high for 3 more cycles
        set_in(1'b0, 12'd0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        tick(); tick(); tick();
        set_in(1'b0, 12'd0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        checks++; if (bus_a.acc_out !== 12'd40) begin failures++; $display("FAIL ign_hold_acc: got %0d want 40", bus_a.acc_out); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL ign_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_async_reset();
        done_cnt = 0;
        start_neuron(12'd0);
        pair(16'hFFFF, 16'hFFFF, 1'b0);
        pair(16'hFFFF, 16'hFFFF, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus_a.busy !== 1'b0) begin failures++; $display("FAIL arst_busy: got %b want 0", bus_a.busy); end
        checks++; if (bus_a.acc_out !== 12'd0 || bus_a.y_bit !== 1'b0) begin failures++; $display("FAIL arst_out: got acc=%0d y=%b want 0 0", bus_a.acc_out, bus_a.y_bit); end
        set_in(1'b0, 12'd0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        tick(); tick();
        rst = 1'b1;
        set_in(1'b0, 12'd0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        checks++; if (done_cnt !== 0) begin failures++; $display("FAIL arst_no_done: got %0d want 0", done_cnt); end
        start_neuron(12'd16);
        pair(16'hFFFF, 16'hFFFF, 1'b1);
        checks++; if (bus_a.acc_out !== 12'd16 || bus_a.y_bit !== 1'b1) begin failures++; $display("FAIL arst_fresh: got acc=%0d y=%b want 16 1", bus_a.acc_out, bus_a.y_bit); end
        checks++; if (bus_a.done !== 1'b1) begin failures++; $display("FAIL arst_fresh_done: got %b want 1", bus_a.done); end
        tick();
    endtask

    task automatic test_saturate();
        start_neuron(12'd31);
        pair(16'hFFFF, 16'hFFFF, 1'b0);
        pair(16'hFFFF, 16'hFFFF, 1'b0);
        pair(16'hFFFF, 16'hFFFF, 1'b1);
        checks++; if (bus_b.acc_out !== 5'd31) begin failures++; $display("FAIL sat_acc: got %0d want 31", bus_b.acc_out); end
        checks++; if (bus_b.y_bit !== 1'b1) begin failures++; $display("FAIL sat_y: got %b want 1", bus_b.y_bit); end
        checks++; if (bus_b.done !== 1'b1) begin failures++; $display("FAIL sat_done: got %b want 1", bus_b.done); end
        checks++; if (bus_a.acc_out !== 12'd48) begin failures++; $display("FAIL wide_acc: got %0d want 48", bus_a.acc_out); end
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        done_cnt = 0;
        test_reset();
        test_full_match();
        test_zero_match();
        test_gaps();
        test_ignored();
        test_async_reset();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
